// File: rtl/ram_pkg.sv
// Shared types and constants for the RAM bus controller slice.
package ram_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    XFER,
    DONE
  } state_t;

endpackage

// File: rtl/ram_array.sv
// 2**ADDR_W x DATA_W storage with one synchronous write port and one registered read port.
// With RAM_PROGRAM_EN defined, a programming write shares the write port.
module ram_array
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
`ifdef RAM_PROGRAM_EN
  input  logic              prog_wr_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`endif
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // Controller writes win; the two sources never overlap since programming is IDLE-only.
  always_comb begin
    w_en   = wr_en;
    w_addr = wr_addr;
    w_data = wr_data;
`ifdef RAM_PROGRAM_EN
    if (!wr_en && prog_wr_en) begin
      w_en   = 1'b1;
      w_addr = prog_addr;
      w_data = prog_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_bus_controller.sv
// CPU <-> RAM single-byte transfer sequencer with transceiver turnaround control.
// Optional feature macro: RAM_PROGRAM_EN (adds the prog_* direct-write port).
module ram_bus_controller
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef RAM_PROGRAM_EN
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
`endif
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              xcvr_oe_n,
  output logic              xcvr_dir
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] mar;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dir_q;
  logic              accept;
  logic              req_dir;
  logic              mem_wr_en;
  logic              mem_rd_en;

`ifdef RAM_PROGRAM_EN
  assign accept = req && !prog_en;
`else
  assign accept = req;
`endif
  assign req_dir = we ? DIR_WRITE : DIR_READ;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The direction only flips at the end of TURN, while the transceiver is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar     <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      dir_q   <= DIR_WRITE;
    end else begin
      if (state == IDLE && accept) begin
        mar     <= addr;
        we_q    <= we;
        wdata_q <= wdata;
      end
      if (state == TURN) dir_q <= we_q ? DIR_WRITE : DIR_READ;
    end
  end

  always_comb begin
    next_state = state;
    ack        = 1'b0;
    busy       = 1'b1;
    xcvr_oe_n  = 1'b1;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) next_state = (req_dir != dir_q) ? TURN : XFER;
      end
      TURN: next_state = XFER;
      XFER: begin
        xcvr_oe_n  = 1'b0;
        mem_wr_en  = we_q && rst_n;
        mem_rd_en  = !we_q;
        next_state = DONE;
      end
      DONE: begin
        xcvr_oe_n  = 1'b0;
        ack        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign xcvr_dir = dir_q;

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (mem_wr_en),
    .wr_addr   (mar),
    .wr_data   (wdata_q),
`ifdef RAM_PROGRAM_EN
    .prog_wr_en(prog_en && prog_we && state == IDLE),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
`endif
    .rd_en     (mem_rd_en),
    .rd_addr   (mar),
    .rd_data   (rdata)
  );

endmodule

// File: tb/tb_ram_bus_controller.sv
// Directed, scoreboard-based bench for ram_bus_controller (prog_* tests under RAM_PROGRAM_EN).
module tb_ram_bus_controller;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       busy;
  logic       xcvr_oe_n;
  logic       xcvr_dir;
`ifdef RAM_PROGRAM_EN
  logic       prog_en;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
`endif

  typedef struct {
    logic       is_read;
    logic [7:0] data;
    int         lat;
  } txn_t;

  txn_t       sb[$];
  logic [7:0] model_mem [0:15];
  logic       model_dir;
  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  int         fail_cnt = 0;

  ram_bus_controller #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
`ifdef RAM_PROGRAM_EN
    .prog_en  (prog_en),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
`endif
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .xcvr_oe_n(xcvr_oe_n),
    .xcvr_dir (xcvr_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one transaction, push its expectation, wait (bounded) for ack and pop/compare.
  task automatic applyStimulus(input logic t_we, input logic [3:0] t_addr, input logic [7:0] t_data);
    txn_t item;
    int   edges;
    bit   got;
    item.is_read = !t_we;
    item.data    = t_we ? 8'h00 : model_mem[t_addr];
    item.lat     = ((t_we ? 1'b0 : 1'b1) != model_dir) ? 3 : 2;
    sb.push_back(item);
    if (t_we) model_mem[t_addr] = t_data;
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_data;
    edges = 0;
    got   = 0;
    while (!got && edges < 10) begin
      tick();
      edges++;
      if (edges == 1) checkOutput("oe_after_accept", {31'b0, xcvr_oe_n}, {31'b0, item.lat == 3});
      if (xcvr_oe_n === 1'b0) checkOutput("dir_while_oe", {31'b0, xcvr_dir}, {31'b0, !t_we});
      if (ack === 1'b1) got = 1;
    end
    req       = 1'b0;
    model_dir = !t_we;
    if (!got) begin
      checkOutput("ack_timeout", {31'b0, ack}, 32'd1);
    end else begin
      item = sb.pop_front();
      checkOutput("ack_latency", edges, item.lat);
      if (item.is_read) checkOutput("rdata", {24'b0, rdata}, {24'b0, item.data});
      tick();
      checkOutput("ack_pulse", {31'b0, ack}, 32'd0);
    end
  endtask

  initial begin
    logic [5:0] pat;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_dir = 1'b0;
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 4'h0;
    wdata = 8'h00;
`ifdef RAM_PROGRAM_EN
    prog_en   = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;
`endif

    tick();
    tick();
    checkOutput("rst_ack",   {31'b0, ack},       32'd0);
    checkOutput("rst_rdata", {24'b0, rdata},     32'h00);
    checkOutput("rst_busy",  {31'b0, busy},      32'd0);
    checkOutput("rst_oe_n",  {31'b0, xcvr_oe_n}, 32'd1);
    checkOutput("rst_dir",   {31'b0, xcvr_dir},  32'd0);
    rst_n = 1'b1;
    tick();

    applyStimulus(1'b1, 4'd15, 8'h3C);
    applyStimulus(1'b1, 4'd3,  8'hA5);
    applyStimulus(1'b1, 4'd5,  8'h11);
    applyStimulus(1'b0, 4'd3,  8'h00);
    applyStimulus(1'b0, 4'd15, 8'h00);

    // Held request: acks land on edges 2 and 5 only.
    pat   = 6'b010010;
    req   = 1'b1;
    we    = 1'b0;
    addr  = 4'd15;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("held_ack", {31'b0, ack}, {31'b0, pat[i]});
    end
    req = 1'b0;
    checkOutput("held_rdata", {24'b0, rdata}, 32'h3C);
    checkOutput("held_idle",  {31'b0, busy},  32'd0);

    // Reset during XFER of a write: read-to-write turnaround puts XFER two edges out.
    req   = 1'b1;
    we    = 1'b1;
    addr  = 4'd5;
    wdata = 8'h77;
    tick();
    tick();
    checkOutput("xfer_oe_n", {31'b0, xcvr_oe_n}, 32'd0);
    rst_n = 1'b0;
    req   = 1'b0;
    tick();
    checkOutput("midrst_ack",  {31'b0, ack},      32'd0);
    checkOutput("midrst_busy", {31'b0, busy},     32'd0);
    checkOutput("midrst_dir",  {31'b0, xcvr_dir}, 32'd0);
    tick();
    rst_n     = 1'b1;
    model_dir = 1'b0;
    tick();
    applyStimulus(1'b0, 4'd5, 8'h00);

`ifdef RAM_PROGRAM_EN
    prog_en   = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 4'd9;
    prog_data = 8'h42;
    req       = 1'b1;
    we        = 1'b0;
    addr      = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("prog_no_ack",  {31'b0, ack},  32'd0);
      checkOutput("prog_no_busy", {31'b0, busy}, 32'd0);
    end
    prog_en = 1'b0;
    prog_we = 1'b0;
    req     = 1'b0;
    model_mem[9] = 8'h42;
    tick();
    applyStimulus(1'b0, 4'd9, 8'h00);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
